// File: rtl/immgen.sv
// RV32I immediate generator: combinational sign-extended immediate for the
// I/S/B/U/J formats, plus a stall-able registered copy with async reset.
package immtypes_pkg;
  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_U = 3'd3,
    IMM_J = 3'd4
  } imm_sel_e;
endpackage

module immgen
  import immtypes_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  imm_sel_e    imm_sel,
  input  logic        en,
  output logic [31:0] imm_out,
  output logic        imm_err,
  output logic [31:0] imm_q,
  output logic        imm_err_q
);

  logic sign;
  assign sign = instr[31];

  always_comb begin
    imm_out = 32'h0000_0000;
    imm_err = 1'b0;
    case (imm_sel)
      IMM_I: imm_out = {{20{sign}}, instr[31:20]};
      IMM_S: imm_out = {{20{sign}}, instr[31:25], instr[11:7]};
      IMM_B: imm_out = {{20{sign}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U: imm_out = {instr[31:12], 12'b0};
      IMM_J: imm_out = {{12{sign}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      // Encodings 5..7 have no format: force a clean zero and flag it.
      default: begin
        imm_out = 32'h0000_0000;
        imm_err = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imm_q     <= 32'h0000_0000;
      imm_err_q <= 1'b0;
    end else if (en) begin
      imm_q     <= imm_out;
      imm_err_q <= imm_err;
    end
  end

endmodule

// File: tb/tb_immgen.sv
// Self-checking bench for immgen: directed vector table, randomized format
// sweep against an arithmetic reference, and registered-path sequences.
module tb_immgen;
  import immtypes_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [31:0] instr;
  imm_sel_e    imm_sel;
  logic        en;
  logic [31:0] imm_out;
  logic        imm_err;
  logic [31:0] imm_q;
  logic        imm_err_q;

  int errors = 0;
  int checks = 0;

  immgen dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .instr     (instr),
    .imm_sel   (imm_sel),
    .en        (en),
    .imm_out   (imm_out),
    .imm_err   (imm_err),
    .imm_q     (imm_q),
    .imm_err_q (imm_err_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [2:0]  sel;
    logic [31:0] exp_imm;
    logic        exp_err;
  } vec_t;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Reference model built from shifts/masks on the signed word rather than
  // bit concatenation.
  function automatic logic [31:0] ref_imm(input logic [31:0] w, input logic [2:0] sel);
    logic [31:0] hi;
    hi = 32'($signed(w) >>> 20);
    case (sel)
      3'd0: ref_imm = hi;
      3'd1: ref_imm = (hi & ~32'h1F) | ((w >> 7) & 32'h1F);
      3'd2: ref_imm = (hi & ~32'hFFF) | ((w & 32'h80) << 4)
                      | ((w >> 20) & 32'h7E0) | ((w >> 7) & 32'h1E);
      3'd3: ref_imm = w & 32'hFFFF_F000;
      3'd4: ref_imm = (32'($signed(w) >>> 11) & 32'hFFF0_0000) | (w & 32'h000F_F000)
                      | ((w >> 9) & 32'h800) | ((w >> 20) & 32'h7FE);
      default: ref_imm = 32'h0;
    endcase
  endfunction

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{32'hFFF00093, 3'd0, 32'hFFFFFFFF, 1'b0};
    vecs[1]  = '{32'h7FF00093, 3'd0, 32'h000007FF, 1'b0};
    vecs[2]  = '{32'hFE112E23, 3'd1, 32'hFFFFFFFC, 1'b0};
    vecs[3]  = '{32'h80000063, 3'd2, 32'hFFFFF000, 1'b0};
    // bit7=1, [11:8]=F, [30:25]=0 -> 0x800 | 0x01E
    vecs[4]  = '{32'h00000FE3, 3'd2, 32'h0000081E, 1'b0};
    vecs[5]  = '{32'h7E000FE3, 3'd2, 32'h00000FFE, 1'b0};
    vecs[6]  = '{32'h123452B7, 3'd3, 32'h12345000, 1'b0};
    vecs[7]  = '{32'h800000EF, 3'd4, 32'hFFF00000, 1'b0};
    vecs[8]  = '{32'h7FFFF0EF, 3'd4, 32'h000FFFFE, 1'b0};
    vecs[9]  = '{32'hFFFFFFFF, 3'd7, 32'h00000000, 1'b1};
    vecs[10] = '{32'h12345678, 3'd5, 32'h00000000, 1'b1};
    vecs[11] = '{32'hA5A5A5A5, 3'd6, 32'h00000000, 1'b1};

    rst_n   = 1'b0;
    en      = 1'b0;
    instr   = 32'h0;
    imm_sel = IMM_I;
    #3;
    check32("reset_imm_q", imm_q, 32'h0);
    check1("reset_imm_err_q", imm_err_q, 1'b0);

    // Combinational path must work while reset is held.
    foreach (vecs[i]) begin
      instr   = vecs[i].instr;
      imm_sel = imm_sel_e'(vecs[i].sel);
      #1;
      check32($sformatf("vec%0d_imm", i), imm_out, vecs[i].exp_imm);
      check1($sformatf("vec%0d_err", i), imm_err, vecs[i].exp_err);
    end
    check32("reset_holds_q", imm_q, 32'h0);

    for (int f = 0; f < 5; f++) begin
      for (int n = 0; n < 50000; n++) begin
        instr   = $urandom;
        imm_sel = imm_sel_e'(f[2:0]);
        #1;
        check32($sformatf("rand_fmt%0d_imm", f), imm_out, ref_imm(instr, f[2:0]));
        if (n % 1000 == 0) check1($sformatf("rand_fmt%0d_err", f), imm_err, 1'b0);
      end
    end
    for (int n = 0; n < 300; n++) begin
      logic [2:0] s;
      s       = 3'(5 + (n % 3));
      instr   = $urandom;
      imm_sel = imm_sel_e'(s);
      #1;
      check32("rand_undef_imm", imm_out, 32'h0);
      check1("rand_undef_err", imm_err, 1'b1);
    end

    @(negedge clk);
    rst_n   = 1'b1;
    en      = 1'b1;
    instr   = 32'hFFF00093;
    imm_sel = IMM_I;
    #1;
    check32("pre_edge_q", imm_q, 32'h0);
    @(posedge clk); #1;
    check32("first_update_q", imm_q, 32'hFFFFFFFF);
    check1("first_update_err_q", imm_err_q, 1'b0);

    @(negedge clk);
    en    = 1'b0;
    instr = 32'h7FF00093;
    repeat (2) @(posedge clk);
    #1;
    check32("stall_hold_q", imm_q, 32'hFFFFFFFF);
    check32("stall_comb_live", imm_out, 32'h000007FF);

    @(negedge clk);
    en      = 1'b1;
    imm_sel = imm_sel_e'(3'd7);
    @(posedge clk); #1;
    check32("undef_q", imm_q, 32'h0);
    check1("undef_err_q", imm_err_q, 1'b1);

    @(negedge clk);
    imm_sel = IMM_I;
    @(posedge clk); #1;
    check32("recover_q", imm_q, 32'h000007FF);
    check1("recover_err_q", imm_err_q, 1'b0);

    @(negedge clk);
    imm_sel = imm_sel_e'(3'd6);
    @(posedge clk); #1;
    check1("err_q_set", imm_err_q, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check32("async_reset_q", imm_q, 32'h0);
    check1("async_reset_err_q", imm_err_q, 1'b0);
    check1("async_reset_comb_err", imm_err, 1'b1);

    @(posedge clk); #1;
    check32("reset_held_q", imm_q, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
